// File: rtl/start_screen_pkg.sv
// start_screen_pkg: shared state type, bus width and RGB565 helper for the start-screen fetch
package start_screen_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
  localparam int ADDR_W = 12;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] w);
    return {w[R_LSB +: 5], w[R_LSB + 2 +: 3], w[G_LSB +: 6], w[G_LSB + 4 +: 2], w[B_LSB +: 5], w[B_LSB + 2 +: 3]};
  endfunction
endpackage

// File: rtl/start_screen_fetch_if.sv
// start_screen_fetch_if: read bus to the single-port start-screen image RAM
interface start_screen_fetch_if;
  import start_screen_pkg::*;
  logic [ADDR_W-1:0] rom_address;
  logic rom_chipselect;
  logic rom_clken;
  logic [15:0] rom_readdata;
  modport master (output rom_address, rom_chipselect, rom_clken, input rom_readdata);
  modport slave (input rom_address, rom_chipselect, rom_clken, output rom_readdata);
endinterface

// File: rtl/start_linebuf.sv
// start_linebuf: one image row of RGB565 words, synchronous write, combinational read
module start_linebuf #(
  parameter int IMG_W = 64,
  localparam int AW = $clog2(IMG_W)
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [15:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [15:0] rdata
);
  logic [15:0] mem [IMG_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/start_screen_fetch.sv
// start_screen_fetch: prefetches one image row per blank and streams scaled pixels during active video
module start_screen_fetch #(
  parameter int X0 = 192,
  parameter int Y0 = 112,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int SCALE_LOG2 = 2,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input logic clk,
  input logic reset,
  input logic enable,
  input logic line_start,
  input logic [9:0] next_y,
  input logic [9:0] x,
  input logic active,
  start_screen_fetch_if.master rom,
  output logic [23:0] pixel_rgb,
  output logic pixel_hit,
  output logic busy
);
  import start_screen_pkg::*;
  localparam int CW = $clog2(IMG_W);
  localparam logic [9:0] X_HI = 10'(X0 + (IMG_W << SCALE_LOG2));
  localparam logic [9:0] Y_HI = 10'(Y0 + (IMG_H << SCALE_LOG2));
  fetch_state_t state;
  logic [CW-1:0] col, rd_idx, idx;
  logic [ADDR_W-1:0] addr, new_base;
  logic cs, rd_v, buf_valid, y_hit, in_region;
  logic [15:0] w;
  assign y_hit = next_y >= 10'(Y0) && next_y < Y_HI;
  assign new_base = ADDR_W'(((next_y - 10'(Y0)) >> SCALE_LOG2) * IMG_W);
  // rd_v/rd_idx track the address the RAM sampled last edge, so its data lands one edge later
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      col <= '0;
      addr <= '0;
      cs <= 1'b0;
      rd_v <= 1'b0;
      rd_idx <= '0;
      buf_valid <= 1'b0;
    end else begin
      rd_v <= cs;
      rd_idx <= col;
      if (!enable) begin
        state <= IDLE;
        cs <= 1'b0;
        buf_valid <= 1'b0;
      end else if (line_start) begin
        state <= y_hit ? FETCH : IDLE;
        cs <= y_hit;
        col <= '0;
        addr <= y_hit ? new_base : addr;
        buf_valid <= 1'b0;
      end else if (state == FETCH) begin
        if (col == CW'(IMG_W - 1)) begin
          state <= DRAIN;
          cs <= 1'b0;
        end else begin
          col <= col + CW'(1);
          addr <= addr + ADDR_W'(1);
        end
      end else if (state == DRAIN) begin
        state <= IDLE;
        buf_valid <= 1'b1;
      end
    end
  start_linebuf #(.IMG_W(IMG_W)) u_buf (
    .clk(clk),
    .we(rd_v),
    .waddr(rd_idx),
    .wdata(rom.rom_readdata),
    .raddr(idx),
    .rdata(w)
  );
  assign in_region = enable & active & buf_valid & x >= 10'(X0) & x < X_HI;
  assign idx = CW'((x - 10'(X0)) >> SCALE_LOG2);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pixel_rgb <= '0;
      pixel_hit <= 1'b0;
    end else begin
      pixel_rgb <= in_region ? rgb565_to_888(w) : '0;
      pixel_hit <= in_region & (w != TRANSPARENT);
    end
  assign rom.rom_address = addr;
  assign rom.rom_chipselect = cs;
  assign rom.rom_clken = cs;
  assign busy = state != IDLE;
endmodule
